// File: rtl/dual_edge_ff_sched.sv
// Round-robin scheduler sharing one dual-edge FF bank; bursts lock the bank to their owner.
// Bank outputs registered, 1-cycle latency; req_ready is combinational and one-hot or zero.
module dual_edge_ff_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int LEN_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_mask,
    input  logic [NUM_REQ*2-1:0]          req_edge,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len,
    output logic [DATA_WIDTH-1:0]         ff_data_in,
    output logic [DATA_WIDTH-1:0]         ff_pos_en,
    output logic [DATA_WIDTH-1:0]         ff_neg_en,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                state_q;
    logic [IDW-1:0]        rr_q;
    logic [IDW-1:0]        owner_q;
    logic [LEN_W-1:0]      remain_q;
    logic [DATA_WIDTH-1:0] ff_data_q;
    logic [DATA_WIDTH-1:0] ff_pos_q;
    logic [DATA_WIDTH-1:0] ff_neg_q;
    logic [IDW-1:0]        grant_q;
    logic                  busy_q;

    logic                  win_vld;
    logic [IDW-1:0]        win_id;
    logic [IDW-1:0]        sel_id;
    logic                  sel_vld;
    logic                  accept;
    logic [IDW-1:0]        nxt_ptr;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [DATA_WIDTH-1:0] beat_mask;
    logic [1:0]            beat_edge;
    logic [LEN_W-1:0]      beat_len;

    // Search downward so the candidate closest to rr_q overwrites the others.
    always_comb begin
        int             t;
        logic [IDW-1:0] idx;
        win_vld = 1'b0;
        win_id  = '0;
        t       = 0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            t = int'(rr_q) + k;
            if (t >= NUM_REQ) begin
                t = t - NUM_REQ;
            end
            idx = IDW'(t);
            if (req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_comb begin
        sel_id    = (state_q == BURST) ? owner_q : win_id;
        sel_vld   = (state_q == BURST) ? req_valid[owner_q] : win_vld;
        accept    = sel_vld && !rst;
        req_ready = '0;
        if (accept) begin
            req_ready[sel_id] = 1'b1;
        end
        nxt_ptr   = (sel_id == IDW'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
        beat_data = req_data[int'(sel_id)*DATA_WIDTH +: DATA_WIDTH];
        beat_mask = req_mask[int'(sel_id)*DATA_WIDTH +: DATA_WIDTH];
        beat_edge = req_edge[int'(sel_id)*2 +: 2];
        beat_len  = req_len[int'(sel_id)*LEN_W +: LEN_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            remain_q  <= '0;
            ff_data_q <= '0;
            ff_pos_q  <= '0;
            ff_neg_q  <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            // Enables pulse only on the cycle after an accepted beat; data and id hold.
            ff_pos_q <= '0;
            ff_neg_q <= '0;
            if (accept) begin
                ff_data_q <= beat_data;
                ff_pos_q  <= beat_mask & {DATA_WIDTH{beat_edge[0]}};
                ff_neg_q  <= beat_mask & {DATA_WIDTH{beat_edge[1]}};
                grant_q   <= sel_id;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q  <= sel_id;
                        remain_q <= beat_len;
                        if (beat_len == '0) begin
                            rr_q <= nxt_ptr;
                        end else begin
                            state_q <= BURST;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (accept) begin
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == LEN_W'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            rr_q    <= nxt_ptr;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ff_data_in = ff_data_q;
    assign ff_pos_en  = ff_pos_q;
    assign ff_neg_en  = ff_neg_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dual_edge_ff_sched.sv
// Directed bench for dual_edge_ff_sched: driver queues expected bank outputs, monitor compares.
module tb_dual_edge_ff_sched;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_data;
    logic [NR*DW-1:0]  req_mask;
    logic [NR*2-1:0]   req_edge;
    logic [NR*LW-1:0]  req_len;
    logic [DW-1:0]     ff_data_in;
    logic [DW-1:0]     ff_pos_en;
    logic [DW-1:0]     ff_neg_en;
    logic [1:0]        grant_id;
    logic              busy;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] p;
        logic [7:0] n;
        logic [1:0] id;
        logic       b;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    dual_edge_ff_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mask(req_mask),
        .req_edge(req_edge), .req_len(req_len),
        .ff_data_in(ff_data_in), .ff_pos_en(ff_pos_en), .ff_neg_en(ff_neg_en),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [7:0] m,
                           input logic [1:0] e, input logic [3:0] l);
        req_data[i*DW +: DW] = d;
        req_mask[i*DW +: DW] = m;
        req_edge[i*2 +: 2]   = e;
        req_len[i*LW +: LW]  = l;
    endtask

    // One clock: drive valids, check combinational ready, queue the bank state expected after the edge.
    task automatic step(input logic [3:0] v, input logic [3:0] rdy,
                        input logic [7:0] d, input logic [7:0] p, input logic [7:0] n,
                        input logic [1:0] id, input logic b, input string nm);
        req_valid = v;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(req_ready), 32'(rdy));
        exp_q.push_back(exp_t'({d, p, n, id, b}));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        exp_t  e;
        exp_t  g;
        string nm;
        #2;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = exp_t'({ff_data_in, ff_pos_en, ff_neg_en, grant_id, busy});
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got data=%h pos=%h neg=%h id=%0d busy=%b expected data=%h pos=%h neg=%h id=%0d busy=%b",
                         nm, g.d, g.p, g.n, g.id, g.b, e.d, e.p, e.n, e.id, e.b);
            end
        end
    end

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_mask  = '0;
        req_edge  = '0;
        req_len   = '0;

        #1 rst = 1'b1;
        #2;
        chk("rst_data", 32'(ff_data_in), 32'h0);
        chk("rst_pos",  32'(ff_pos_en),  32'h0);
        chk("rst_neg",  32'(ff_neg_en),  32'h0);
        chk("rst_id",   32'(grant_id),   32'h0);
        chk("rst_busy", 32'(busy),       32'h0);
        req_valid = 4'hF;
        #1 chk("rst_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Single beat from requester 0
        set_req(0, 8'hA5, 8'hFF, 2'b01, 4'd0);
        step(4'b0001, 4'b0001, 8'hA5, 8'hFF, 8'h00, 2'd0, 1'b0, "single");
        step(4'b0000, 4'b0000, 8'hA5, 8'h00, 8'h00, 2'd0, 1'b0, "single_idle");

        // Round-robin, pointer now at 1
        set_req(0, 8'h11, 8'hFF, 2'b01, 4'd0);
        set_req(1, 8'h22, 8'hF0, 2'b10, 4'd0);
        set_req(2, 8'h33, 8'h0F, 2'b11, 4'd0);
        set_req(3, 8'h44, 8'hAA, 2'b01, 4'd0);
        step(4'b1111, 4'b0010, 8'h22, 8'h00, 8'hF0, 2'd1, 1'b0, "rr_1");
        step(4'b1111, 4'b0100, 8'h33, 8'h0F, 8'h0F, 2'd2, 1'b0, "rr_2");
        step(4'b1111, 4'b1000, 8'h44, 8'hAA, 8'h00, 2'd3, 1'b0, "rr_3");
        step(4'b1111, 4'b0001, 8'h11, 8'hFF, 8'h00, 2'd0, 1'b0, "rr_0");
        step(4'b1111, 4'b0010, 8'h22, 8'h00, 8'hF0, 2'd1, 1'b0, "rr_1b");
        step(4'b0000, 4'b0000, 8'h22, 8'h00, 8'h00, 2'd1, 1'b0, "rr_idle");
        step(4'b0100, 4'b0100, 8'h33, 8'h0F, 8'h0F, 2'd2, 1'b0, "rr_adv");

        // Burst lock: req1 len 3 while req2 waits; later len changes are ignored
        set_req(1, 8'h5A, 8'hFF, 2'b01, 4'd3);
        step(4'b0110, 4'b0010, 8'h5A, 8'hFF, 8'h00, 2'd1, 1'b1, "lock_b0");
        set_req(1, 8'h5B, 8'hFF, 2'b01, 4'd0);
        step(4'b0110, 4'b0010, 8'h5B, 8'hFF, 8'h00, 2'd1, 1'b1, "lock_b1");
        set_req(1, 8'h5C, 8'hFF, 2'b01, 4'd0);
        step(4'b0110, 4'b0010, 8'h5C, 8'hFF, 8'h00, 2'd1, 1'b1, "lock_b2");
        set_req(1, 8'h5D, 8'hFF, 2'b01, 4'd0);
        step(4'b0110, 4'b0010, 8'h5D, 8'hFF, 8'h00, 2'd1, 1'b0, "lock_b3");
        step(4'b0110, 4'b0100, 8'h33, 8'h0F, 8'h0F, 2'd2, 1'b0, "lock_next");

        // Mid-burst bubble: req0 len 2, owner drops valid for two cycles, req2 stays blocked
        set_req(0, 8'h70, 8'hFF, 2'b10, 4'd2);
        step(4'b0001, 4'b0001, 8'h70, 8'h00, 8'hFF, 2'd0, 1'b1, "bub_b0");
        set_req(0, 8'h71, 8'hFF, 2'b10, 4'd0);
        step(4'b0001, 4'b0001, 8'h71, 8'h00, 8'hFF, 2'd0, 1'b1, "bub_b1");
        step(4'b0100, 4'b0000, 8'h71, 8'h00, 8'h00, 2'd0, 1'b1, "bub_gap0");
        step(4'b0100, 4'b0000, 8'h71, 8'h00, 8'h00, 2'd0, 1'b1, "bub_gap1");
        set_req(0, 8'h72, 8'hFF, 2'b10, 4'd0);
        step(4'b0101, 4'b0001, 8'h72, 8'h00, 8'hFF, 2'd0, 1'b0, "bub_b2");

        // Edge/mask: both edges, then a no-op beat that still closes the burst
        set_req(1, 8'h3C, 8'h0F, 2'b11, 4'd1);
        step(4'b0010, 4'b0010, 8'h3C, 8'h0F, 8'h0F, 2'd1, 1'b1, "em_b11");
        set_req(1, 8'hC3, 8'h0F, 2'b00, 4'd0);
        step(4'b0010, 4'b0010, 8'hC3, 8'h00, 8'h00, 2'd1, 1'b0, "em_b00");
        set_req(1, 8'h99, 8'hFF, 2'b01, 4'd0);
        step(4'b0010, 4'b0010, 8'h99, 8'hFF, 8'h00, 2'd1, 1'b0, "em_after");

        // Async reset in the middle of a len 5 burst
        set_req(3, 8'hE0, 8'hFF, 2'b11, 4'd5);
        step(4'b1000, 4'b1000, 8'hE0, 8'hFF, 8'hFF, 2'd3, 1'b1, "ar_b0");
        set_req(3, 8'hE1, 8'hFF, 2'b11, 4'd0);
        step(4'b1000, 4'b1000, 8'hE1, 8'hFF, 8'hFF, 2'd3, 1'b1, "ar_b1");
        #2 rst = 1'b1;
        #1;
        chk("ar_data",  32'(ff_data_in), 32'h0);
        chk("ar_pos",   32'(ff_pos_en),  32'h0);
        chk("ar_neg",   32'(ff_neg_en),  32'h0);
        chk("ar_id",    32'(grant_id),   32'h0);
        chk("ar_busy",  32'(busy),       32'h0);
        chk("ar_ready", 32'(req_ready),  32'h0);
        req_valid = '0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        set_req(0, 8'h81, 8'hFF, 2'b01, 4'd0);
        set_req(3, 8'hE7, 8'hFF, 2'b11, 4'd0);
        step(4'b1001, 4'b0001, 8'h81, 8'hFF, 8'h00, 2'd0, 1'b0, "ar_restart");
        step(4'b1001, 4'b1000, 8'hE7, 8'hFF, 8'hFF, 2'd3, 1'b0, "ar_next");
        step(4'b0000, 4'b0000, 8'hE7, 8'h00, 8'h00, 2'd3, 1'b0, "final_idle");

        repeat (3) @(posedge clk);
        #3;
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
